// File: rtl/apb_fll_if.sv
// APB slave bridge to up to four FLL register ports.
// Adds a local lock STATUS register and one outstanding FLL request at a time.
module apb_fll_if #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned NR_FLLS        = 3
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [APB_ADDR_WIDTH-1:0]       paddr,
    input  logic [31:0]                     pwdata,
    input  logic                            pwrite,
    input  logic                            psel,
    input  logic                            penable,
    output logic [31:0]                     prdata,
    output logic                            pready,
    output logic                            pslverr,
    output logic [NR_FLLS-1:0]              fll_req_o,
    output logic [NR_FLLS-1:0]              fll_wrn_o,
    output logic [NR_FLLS-1:0][1:0]         fll_add_o,
    output logic [NR_FLLS-1:0][31:0]        fll_data_o,
    input  logic [NR_FLLS-1:0]              fll_ack_i,
    input  logic [NR_FLLS-1:0][31:0]        fll_r_data_i,
    input  logic [NR_FLLS-1:0]              fll_lock_i
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADD_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                           state_q, state_d;
    logic [NR_FLLS-1:0]               sel_q, sel_d;
    logic [NR_FLLS-1:0]               req_d, wrn_d;
    logic [NR_FLLS-1:0][ADD_W-1:0]    add_d;
    logic [NR_FLLS-1:0][DATA_W-1:0]   data_d;
    logic [DATA_W-1:0]                prdata_d;
    logic                             pready_d;
    logic                             pslverr_d;

    logic                             access;
    logic                             is_status;
    logic [1:0]                       fll_idx;
    logic [NR_FLLS-1:0]               idx_sel;
    logic                             idx_ok;
    logic                             ack_hit;
    logic                             is_read;
    logic [DATA_W-1:0]                sel_rdata;
    logic                             unused_paddr;

    assign access       = psel & penable;
    assign is_status    = paddr[6];
    assign fll_idx      = paddr[5:4];
    assign idx_ok       = |idx_sel;
    assign ack_hit      = |(fll_ack_i & sel_q);
    assign is_read      = |(fll_wrn_o & sel_q);
    assign unused_paddr = ^{paddr[1:0], paddr >> 7};

    // Address decode and read-data mux for the FLL currently being served
    always_comb begin
        idx_sel   = '0;
        sel_rdata = '0;
        for (int i = 0; i < int'(NR_FLLS); i++) begin
            idx_sel[i] = (fll_idx == 2'(i));
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | fll_r_data_i[i];
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            fll_req_o  <= '0;
            fll_wrn_o  <= '0;
            fll_add_o  <= '0;
            fll_data_o <= '0;
            prdata     <= '0;
            pready     <= 1'b0;
            pslverr    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            fll_req_o  <= req_d;
            fll_wrn_o  <= wrn_d;
            fll_add_o  <= add_d;
            fll_data_o <= data_d;
            prdata     <= prdata_d;
            pready     <= pready_d;
            pslverr    <= pslverr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    state_d = (!is_status && idx_ok) ? REQ : DONE;
                end
            end
            REQ:     if (ack_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; FLL signals hold while waiting for ack
    always_comb begin
        sel_d     = sel_q;
        req_d     = fll_req_o;
        wrn_d     = fll_wrn_o;
        add_d     = fll_add_o;
        data_d    = fll_data_o;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    if (is_status) begin
                        pready_d = 1'b1;
                        prdata_d = DATA_W'(fll_lock_i);
                    end else if (idx_ok) begin
                        sel_d = idx_sel;
                        for (int i = 0; i < int'(NR_FLLS); i++) begin
                            if (idx_sel[i]) begin
                                req_d[i]  = 1'b1;
                                wrn_d[i]  = ~pwrite;
                                add_d[i]  = paddr[3:2];
                                data_d[i] = pwdata;
                            end
                        end
                    end else begin
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (ack_hit) begin
                    sel_d    = '0;
                    req_d    = '0;
                    wrn_d    = '0;
                    add_d    = '0;
                    data_d   = '0;
                    pready_d = 1'b1;
                    prdata_d = is_read ? sel_rdata : '0;
                end
            end
            DONE: begin
                sel_d  = '0;
                req_d  = '0;
                wrn_d  = '0;
                add_d  = '0;
                data_d = '0;
            end
            default: begin
                sel_d  = '0;
                req_d  = '0;
                wrn_d  = '0;
                add_d  = '0;
                data_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_fll_if.sv
// Randomized bench for apb_fll_if against a transaction-level reference model.
module tb_apb_fll_if;

    localparam int unsigned AW = 12;
    localparam int unsigned NF = 3;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [AW-1:0]           paddr;
    logic [31:0]             pwdata;
    logic                    pwrite;
    logic                    psel;
    logic                    penable;
    logic [31:0]             prdata;
    logic                    pready;
    logic                    pslverr;
    logic [NF-1:0]           fll_req_o;
    logic [NF-1:0]           fll_wrn_o;
    logic [NF-1:0][1:0]      fll_add_o;
    logic [NF-1:0][31:0]     fll_data_o;
    logic [NF-1:0]           fll_ack_i;
    logic [NF-1:0][31:0]     fll_r_data_i;
    logic [NF-1:0]           fll_lock_i;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic        use_fixed_rd = 1'b0;
    logic [31:0] fixed_rd     = '0;

    always #5 clk_i = ~clk_i;

    apb_fll_if #(.APB_ADDR_WIDTH(AW), .NR_FLLS(NF)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .pwrite       (pwrite),
        .psel         (psel),
        .penable      (penable),
        .prdata       (prdata),
        .pready       (pready),
        .pslverr      (pslverr),
        .fll_req_o    (fll_req_o),
        .fll_wrn_o    (fll_wrn_o),
        .fll_add_o    (fll_add_o),
        .fll_data_o   (fll_data_o),
        .fll_ack_i    (fll_ack_i),
        .fll_r_data_i (fll_r_data_i),
        .fll_lock_i   (fll_lock_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic randomize_fll_rdata();
        for (int i = 0; i < int'(NF); i++) fll_r_data_i[i] = $urandom;
    endtask

    task automatic check_all_quiet(input string tag);
        check({tag, "_req"}, 32'(fll_req_o), 32'h0);
        check({tag, "_wrn"}, 32'(fll_wrn_o), 32'h0);
        check({tag, "_add"}, 32'(fll_add_o), 32'h0);
        for (int i = 0; i < int'(NF); i++) check({tag, "_data"}, fll_data_o[i], 32'h0);
    endtask

    // One APB transfer; the FLL side acks ack_dly cycles after the request appears
    task automatic xfer(input logic [AW-1:0] addr, input logic [31:0] wdata, input logic write,
                        input int ack_dly, input logic [NF-1:0] lock, input logic drop);
        logic              is_st;
        logic              valid;
        int                idx;
        logic [31:0]       exp_rd;
        logic [NF-1:0]     exp_req;
        logic [NF-1:0][1:0] exp_add;

        is_st  = addr[6];
        idx    = int'(addr[5:4]);
        valid  = !is_st && (idx < int'(NF));
        exp_rd = is_st ? 32'(lock) : 32'h0;

        @(posedge clk_i); #1;
        psel = 1'b1; penable = 1'b0; paddr = addr; pwdata = wdata; pwrite = write;
        fll_lock_i = lock;
        fll_ack_i  = NF'($urandom);
        randomize_fll_rdata();
        @(posedge clk_i); #1;
        penable   = 1'b1;
        fll_ack_i = NF'($urandom);
        randomize_fll_rdata();
        @(posedge clk_i); #1;

        if (valid) begin
            exp_req      = NF'(1) << idx;
            exp_add      = '0;
            exp_add[idx] = addr[3:2];
            for (int c = 0; c <= ack_dly; c++) begin
                check("req", 32'(fll_req_o), 32'(exp_req));
                check("wrn", 32'(fll_wrn_o), write ? 32'h0 : 32'(exp_req));
                check("add", 32'(fll_add_o), 32'(exp_add));
                for (int i = 0; i < int'(NF); i++)
                    check("wdata", fll_data_o[i], (i == idx) ? wdata : 32'h0);
                check("pready_wait", 32'(pready), 32'h0);
                check("prdata_wait", prdata, 32'h0);
                if (drop) begin
                    psel = 1'b0; penable = 1'b0;
                end
                randomize_fll_rdata();
                fll_ack_i = NF'($urandom) & ~exp_req;
                if (c == ack_dly) begin
                    fll_ack_i = fll_ack_i | exp_req;
                    if (use_fixed_rd) fll_r_data_i[idx] = fixed_rd;
                    if (!write) exp_rd = fll_r_data_i[idx];
                end
                @(posedge clk_i); #1;
            end
        end

        check("pready", 32'(pready), 32'h1);
        check("pslverr", 32'(pslverr), (!is_st && !valid) ? 32'h1 : 32'h0);
        check("prdata", prdata, exp_rd);
        check("req_done", 32'(fll_req_o), 32'h0);
        psel = 1'b0; penable = 1'b0;
        fll_ack_i = NF'($urandom);
        @(posedge clk_i); #1;
        check("pready_end", 32'(pready), 32'h0);
        check("prdata_end", prdata, 32'h0);
        fll_ack_i = '0;
    endtask

    initial begin
        rst_i = 1'b1; paddr = '0; pwdata = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0;
        fll_ack_i = '0; fll_r_data_i = '0; fll_lock_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_pready", 32'(pready), 32'h0);
        check("rst_pslverr", 32'(pslverr), 32'h0);
        check("rst_prdata", prdata, 32'h0);
        check_all_quiet("rst");
        rst_i = 1'b0;

        // Write FLL1 reg2, ack after 3 cycles
        xfer(12'h018, 32'h1234_5678, 1'b1, 3, 3'b000, 1'b0);

        // Read FLL0 reg1 with immediate ack and fixed read data
        use_fixed_rd = 1'b1; fixed_rd = 32'hCAFE_F00D;
        xfer(12'h004, 32'h0, 1'b0, 0, 3'b000, 1'b0);
        use_fixed_rd = 1'b0;

        // Invalid index 3
        xfer(12'h030, 32'hDEAD_BEEF, 1'b0, 0, 3'b111, 1'b0);

        // STATUS read and ignored write
        xfer(12'h040, 32'h0, 1'b0, 0, 3'b101, 1'b0);
        xfer(12'h040, 32'hFFFF_FFFF, 1'b1, 0, 3'b101, 1'b0);

        // Reset while waiting in REQ
        @(posedge clk_i); #1;
        psel = 1'b1; penable = 1'b0; paddr = 12'h014; pwrite = 1'b0; fll_ack_i = '0;
        @(posedge clk_i); #1;
        penable = 1'b1;
        @(posedge clk_i); #1;
        check("pre_rst_req", 32'(fll_req_o), 32'h2);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0; psel = 1'b0; penable = 1'b0;
        check("mid_rst_pready", 32'(pready), 32'h0);
        check("mid_rst_prdata", prdata, 32'h0);
        check_all_quiet("mid_rst");
        fll_ack_i = 3'b010;
        @(posedge clk_i); #1;
        check("post_rst_pready", 32'(pready), 32'h0);
        check("post_rst_req", 32'(fll_req_o), 32'h0);
        fll_ack_i = '0;
        xfer(12'h028, 32'h0, 1'b0, 2, 3'b000, 1'b0);

        // Back-to-back FLL0 then FLL2, second with the master dropping psel mid-request
        xfer(12'h00C, 32'hA5A5_0001, 1'b1, 1, 3'b010, 1'b0);
        xfer(12'h020, 32'h0, 1'b0, 2, 3'b010, 1'b1);

        for (int t = 0; t < 200; t++) begin
            xfer(AW'($urandom), $urandom, 1'($urandom), int'($urandom_range(0, 4)),
                 NF'($urandom), $urandom_range(0, 7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
